// File: rtl/serial_add_sched.sv
// serial_add_sched: round-robin scheduler sharing one bit-serial adder
// between two requesters; streams operands LSB-first and returns sum+cout.
//
// Ports:
//   clk, reset        clock (rising edge), async active-low reset
//   req0/a0/b0        requester 0 level request and operands
//   req1/a1/b1        requester 1 level request and operands
//   gnt0/gnt1         one-cycle accept pulses (first ADD cycle)
//   busy              high during ADD and DONE
//   done/done_id      one-cycle result-valid pulse and served requester
//   result/cout       WIDTH-bit sum and carry out, held until next done
module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_rr;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_sum;
  logic             r_id;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_busy;
  logic             r_done;
  logic             r_done_id;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_any;
  logic             w_win;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_any = req0 | req1;
  // Contention goes to the pointer; a lone request wins outright.
  assign w_win = (req0 & req1) ? r_rr : req1;

  assign w_s  = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_co = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) |
                (r_b[0] & r_carry);

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Sum enters at the MSB; after WIDTH shifts bit 0 is the first sum bit.
  assign w_sum_nxt = {w_s, r_sum};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rr      <= 1'b0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_id      <= 1'b0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
      r_cout    <= 1'b0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a     <= w_win ? a1 : a0;
            r_b     <= w_win ? b1 : b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_id    <= w_win;
            r_rr    <= ~w_win;
            r_gnt0  <= ~w_win;
            r_gnt1  <= w_win;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_co;
          r_sum   <= w_sum_nxt[WIDTH-1:1];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_result  <= w_sum_nxt;
            r_cout    <= w_co;
            r_done_id <= r_id;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign result  = r_result;
  assign cout    = r_cout;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: directed + randomized bench for serial_add_sched
// with an arithmetic/round-robin reference model.
module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         req0 = 1'b0;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic         req1 = 1'b0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [W-1:0] result;
  logic         cout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rr = 1'b0;

  serial_add_sched #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .a0      (a0),
    .b0      (b0),
    .req1    (req1),
    .a1      (a1),
    .b1      (b1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction: predict winner and sum from the requests/operands
  // present before the accepting edge, then follow it to completion.
  task automatic serve(input bit hold, input bit scramble,
                       output int gcyc);
    bit         w;
    logic [W:0] exp;
    int         n;
    int         extra;
    int         busy_low;
    bit         found;
    w = (req0 && req1) ? rr : req1;
    exp = w ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
    found = 1'b0;
    gcyc = -1;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        found = 1'b1;
        break;
      end
    end
    chk("gnt_seen", 64'(found), 64'd1);
    if (!found) return;
    gcyc = cyc;
    chk("gnt_id", 64'(gnt1), 64'(w));
    chk("gnt_excl", 64'(gnt0 && gnt1), 64'd0);
    chk("busy_at_gnt", 64'(busy), 64'd1);
    rr = !w;
    if (!hold) begin
      if (w) req1 = 1'b0;
      else req0 = 1'b0;
    end
    n = 0;
    extra = 0;
    busy_low = 0;
    do begin
      if (scramble) begin
        a0 = W'($urandom);
        b0 = W'($urandom);
        a1 = W'($urandom);
        b1 = W'($urandom);
        if (w) req0 = 1'($urandom);
        else req1 = 1'($urandom);
      end
      @(negedge clk);
      n++;
      if (gnt0 || gnt1) extra++;
      if (!busy) busy_low++;
    end while (!done && n < 4 * W);
    chk("done_latency", 64'(n), 64'(W));
    chk("gnt_in_op", 64'(extra), 64'd0);
    chk("busy_in_op", 64'(busy_low), 64'd0);
    chk("result", 64'(result), 64'(exp[W-1:0]));
    chk("cout", 64'(cout), 64'(exp[W]));
    chk("done_id", 64'(done_id), 64'(w));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("result_hold", 64'(result), 64'(exp[W-1:0]));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt0"}, 64'(gnt0), 64'd0);
    chk({tag, "_gnt1"}, 64'(gnt1), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_done_id"}, 64'(done_id), 64'd0);
    chk({tag, "_result"}, 64'(result), 64'd0);
    chk({tag, "_cout"}, 64'(cout), 64'd0);
  endtask

  initial begin
    int g;
    int prev;
    bit found;

    // Both requests pending straight out of reset.
    req0 = 1'b1; a0 = 8'h10; b0 = 8'h01;
    req1 = 1'b1; a1 = 8'h20; b1 = 8'h02;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b1;
    serve(1'b0, 1'b0, g);
    serve(1'b0, 1'b0, g);

    // Single requests with fixed operands.
    req0 = 1'b1; a0 = 8'h5A; b0 = 8'h33;
    serve(1'b0, 1'b0, g);
    req1 = 1'b1; a1 = 8'hFF; b1 = 8'h01;
    serve(1'b0, 1'b0, g);
    req1 = 1'b1; a1 = 8'h80; b1 = 8'h80;
    serve(1'b0, 1'b0, g);

    // Both held continuously: alternation and back-to-back spacing.
    req0 = 1'b1;
    req1 = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      serve(1'b1, 1'b0, g);
      if (k > 0) chk("spacing", 64'(g - prev), 64'(W + 2));
      prev = g;
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Random request patterns and operands.
    for (int k = 0; k < 12; k++) begin
      {req0, req1} = 2'($urandom_range(1, 3));
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      serve(1'b0, 1'b0, g);
      req0 = 1'b0;
      req1 = 1'b0;
    end

    // Operands and req1 churn during the operation.
    req0 = 1'b1; req1 = 1'b0;
    a0 = W'($urandom); b0 = W'($urandom);
    serve(1'b0, 1'b1, g);
    req0 = 1'b0; req1 = 1'b1;
    a1 = 8'h33; b1 = 8'h44;
    serve(1'b0, 1'b0, g);

    // Reset in the 4th ADD cycle of 0xFF+0xFF.
    req0 = 1'b1; a0 = 8'hFF; b0 = 8'hFF;
    found = 1'b0;
    for (int i = 0; i < 4 * W; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_gnt_seen", 64'(found), 64'd1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_outs("abort");
    rr = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_done", 64'(done), 64'd0);
    chk("abort_no_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    req0 = 1'b1; a0 = 8'h00; b0 = 8'h00;
    serve(1'b0, 1'b0, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Round-robin scheduler and sequencer that shares one bit-serial full-adder datapath between two requesters.
- Accepts one WIDTH-bit add request at a time and streams operands LSB-first through the 1-bit adder and carry flop.
- Assembles the WIDTH-bit sum and carry-out, then returns them with a done pulse tagged with the requester id.
- Sits between two client blocks and the serial add datapath, which is instantiated inside this block.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk      input   1      system clock, rising edge.
- reset    input   1      asynchronous, active-low reset (0 = reset).
- req0     input   1      requester 0 add request, level; held until gnt0.
- a0       input   WIDTH  requester 0 operand A.
- b0       input   WIDTH  requester 0 operand B.
- req1     input   1      requester 1 add request, level; held until gnt1.
- a1       input   WIDTH  requester 1 operand A.
- b1       input   WIDTH  requester 1 operand B.
- gnt0     output  1      one-cycle pulse: requester 0 accepted, operands captured.
- gnt1     output  1      one-cycle pulse: requester 1 accepted, operands captured.
- busy     output  1      high in ADD and DONE states.
- done     output  1      one-cycle pulse: result/cout/done_id valid.
- done_id  output  1      requester served by the current/last result.
- result   output  WIDTH  sum bits [WIDTH-1:0]; held until next done.
- cout     output  1      carry out of bit WIDTH-1; held until next done.

Behaviour:
- All state flops are registers on the rising edge of clk with asynchronous clear on reset=0.
- Reset values: state=IDLE, rr_ptr=0, bit_cnt=0, carry=0, operand/sum shift regs=0.
- Output reset values: gnt0=gnt1=busy=done=done_id=0, result=0, cout=0.
- States: IDLE -> ADD -> DONE -> IDLE.
- IDLE:
  - req0/req1 sampled only in IDLE; requests in ADD/DONE are ignored until IDLE.
  - Single request: granted regardless of rr_ptr.
  - Both requests: granted to rr_ptr (0 -> req0, 1 -> req1).
  - On the accepting edge: latch winner's a/b into shift regs, carry=0, bit_cnt=0, record id, rr_ptr = ~winner, go to ADD.
- gnt_x is registered: high exactly for the first ADD cycle; gnt0 and gnt1 are never high together.
- ADD, each cycle:
  - s = a_sh[0]^b_sh[0]^carry; carry <= maj(a_sh[0], b_sh[0], carry).
  - a_sh, b_sh shift right; s shifts into sum_sh at the MSB.
  - bit_cnt increments; after exactly WIDTH ADD cycles (bit_cnt==WIDTH-1) go to DONE.
- Transition to DONE loads result<=final sum_sh, cout<=final carry, done_id<=id.
- DONE: done=1 for one cycle, then IDLE.
- Latency: accepting edge E0 -> done high in cycle E0+WIDTH+1; minimum spacing between acceptances is WIDTH+2 cycles.
- Operand inputs are don't-care after the accepting edge; changes must not affect the result.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via cout.
- Reset mid-operation: immediate abort; no done or gnt produced; all outputs return to reset values; next operation starts with carry=0.
- req deasserted before grant: request withdrawn, no effect.

Test Plan:
- WIDTH=8, reset released, req0=1 a0=0x5A b0=0x33 -> gnt0 pulse 1 cycle after accept; done at E0+9 with result=0x8D cout=0 done_id=0; busy high for 9 cycles.
- req1 a1=0xFF b1=0x01 -> result=0x00 cout=1 done_id=1; then a1=0x80 b1=0x80 -> result=0x00 cout=1.
- req0 and req1 both asserted from reset (a0=0x10 b0=0x01, a1=0x20 b1=0x02) -> req0 served first (0x11), req1 next (0x22); done_id 0 then 1; no overlap of gnt.
- req0 and req1 held high continuously for 4 operations -> grants alternate 0,1,0,1; each done spaced exactly 10 cycles.
- Assert reset=0 at 4th ADD cycle of 0xFF+0xFF -> all outputs 0, no done; after release, 0x00+0x00 gives result=0x00 cout=0 (no carry leak).
- After gnt0, change a0/b0 and toggle req1 during ADD -> result matches operands at accept edge; req1 granted only after DONE->IDLE.
